// File: rtl/ptp_frame_gen.sv
// ptp_frame_gen: Wishbone-configured PTPv2 frame generator.
// Software programs the header fields, the body length and the fill word, then
// writes START. The block then streams one frame as bytes on an AXI-Stream
// master: a 34-byte PTPv2 common header followed by N body bytes.
module ptp_frame_gen #(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
    parameter int          HDR_LEN   = 34
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] wbs_addr_i,
    input  logic [31:0] wbs_data_i,
    output logic [31:0] wbs_data_o,
    input  logic        wbs_we_i,
    input  logic        wbs_stb_i,
    output logic        wbs_ack_o,
    output logic [7:0]  axis_tdata_o,
    output logic        axis_tvalid_o,
    input  logic        axis_tready_i,
    output logic        axis_tlast_o
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [11:0] OFF_CTRL = 12'h000;
    localparam logic [11:0] OFF_HDR  = 12'h104;
    localparam logic [11:0] OFF_CORR = 12'h108;
    localparam logic [11:0] OFF_BLEN = 12'h10C;
    localparam logic [11:0] OFF_FILL = 12'h110;

    state_t      state_q, state_d;
    logic [16:0] idx_q, idx_d;

    // Software-visible configuration registers
    logic [31:0] hdr_q, corr_q;
    logic [15:0] blen_q, fill_q;

    // Copies taken at START; the frame in flight only ever reads these
    logic [3:0]  s_mtype_q;
    logic [11:0] s_port_q;
    logic [15:0] s_seq_q;
    logic [31:0] s_corr_q;
    logic [15:0] s_blen_q;
    logic [15:0] s_fill_q;

    logic        ack_q;
    logic [31:0] rdata_q;

    logic        wb_hit, wb_acc, wb_wr, start, busy, last_byte;
    logic [11:0] wb_off;
    logic [31:0] rdata;
    logic [16:0] last_idx;
    logic [15:0] msg_len;
    logic [7:0]  byte_d;

    assign wb_hit = (wbs_addr_i[31:12] == BASE_ADDR[31:12]);
    assign wb_off = wbs_addr_i[11:0];
    // An access is accepted on the edge where ack rises
    assign wb_acc = wbs_stb_i & ~ack_q;
    assign wb_wr  = wb_acc & wbs_we_i & wb_hit;
    assign busy   = (state_q == SEND);
    // START while busy (including the final-handshake cycle) is dropped
    assign start  = wb_wr & (wb_off == OFF_CTRL) & wbs_data_i[0] & ~busy;

    assign last_idx  = 17'(HDR_LEN - 1) + {1'b0, s_blen_q};
    assign msg_len   = 16'(HDR_LEN) + s_blen_q;
    assign last_byte = (idx_q == last_idx);

    // Register read mux; misses and unmapped offsets read as zero
    always_comb begin
        rdata = 32'h0;
        if (wb_hit) begin
            case (wb_off)
                OFF_CTRL: rdata = {30'b0, busy, 1'b0};
                OFF_HDR:  rdata = hdr_q;
                OFF_CORR: rdata = corr_q;
                OFF_BLEN: rdata = {16'h0, blen_q};
                OFF_FILL: rdata = {16'h0, fill_q};
                default:  rdata = 32'h0;
            endcase
        end
    end

    // Wishbone: one-cycle registered ack for every strobe, read data loaded with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            ack_q   <= wb_acc;
            rdata_q <= (wb_acc & ~wbs_we_i) ? rdata : 32'h0;
        end
    end

    // Configuration register writes; accepted even while a frame is in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_q  <= 32'h0;
            corr_q <= 32'h0;
            blen_q <= 16'h0;
            fill_q <= 16'h0;
        end else if (wb_wr) begin
            case (wb_off)
                OFF_HDR:  hdr_q  <= wbs_data_i;
                OFF_CORR: corr_q <= wbs_data_i;
                OFF_BLEN: blen_q <= wbs_data_i[15:0];
                OFF_FILL: fill_q <= wbs_data_i[15:0];
                default:  ;
            endcase
        end
    end

    // Snapshot of the configuration at START
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_mtype_q <= 4'h0;
            s_port_q  <= 12'h0;
            s_seq_q   <= 16'h0;
            s_corr_q  <= 32'h0;
            s_blen_q  <= 16'h0;
            s_fill_q  <= 16'h0;
        end else if (start) begin
            s_mtype_q <= hdr_q[31:28];
            s_port_q  <= hdr_q[27:16];
            s_seq_q   <= hdr_q[15:0];
            s_corr_q  <= corr_q;
            s_blen_q  <= blen_q;
            s_fill_q  <= fill_q;
        end
    end

    // FSM state and byte index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 17'h0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // FSM next state: advance one byte per handshake, leave after the last one
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEND;
                    idx_d   = 17'h0;
                end
            end
            SEND: begin
                if (axis_tready_i) begin
                    if (last_byte) begin
                        state_d = IDLE;
                        idx_d   = 17'h0;
                    end else begin
                        idx_d = idx_q + 17'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame byte selection from the index; everything here is registered state,
    // so tdata holds steady while the sink stalls
    always_comb begin
        byte_d = 8'h00;
        if (idx_q >= 17'(HDR_LEN)) begin
            // Body byte k = idx-34; k and idx share parity, even bytes take the high half
            byte_d = idx_q[0] ? s_fill_q[7:0] : s_fill_q[15:8];
        end else begin
            case (idx_q[5:0])
                6'd0:    byte_d = {4'h0, s_mtype_q};
                6'd1:    byte_d = 8'h02;
                6'd2:    byte_d = msg_len[15:8];
                6'd3:    byte_d = msg_len[7:0];
                6'd12:   byte_d = s_corr_q[31:24];
                6'd13:   byte_d = s_corr_q[23:16];
                6'd14:   byte_d = s_corr_q[15:8];
                6'd15:   byte_d = s_corr_q[7:0];
                6'd28:   byte_d = {4'h0, s_port_q[11:8]};
                6'd29:   byte_d = s_port_q[7:0];
                6'd30:   byte_d = s_seq_q[15:8];
                6'd31:   byte_d = s_seq_q[7:0];
                6'd33:   byte_d = 8'h7F;
                default: byte_d = 8'h00;
            endcase
        end
    end

    assign wbs_ack_o     = ack_q;
    assign wbs_data_o    = rdata_q;
    assign axis_tvalid_o = busy;
    assign axis_tdata_o  = busy ? byte_d : 8'h00;
    assign axis_tlast_o  = busy & last_byte;

endmodule

// File: tb/tb_ptp_frame_gen.sv
// Directed bench for ptp_frame_gen: register access, stalled and streamed
// frames, random backpressure, START while busy, zero-length body, reset abort.
module tb_ptp_frame_gen;

    localparam logic [31:0] BASE = 32'h0300_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h000;
    localparam logic [31:0] A_HDR  = BASE + 32'h104;
    localparam logic [31:0] A_CORR = BASE + 32'h108;
    localparam logic [31:0] A_BLEN = BASE + 32'h10C;
    localparam logic [31:0] A_FILL = BASE + 32'h110;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] wbs_addr_i = '0;
    logic [31:0] wbs_data_i = '0;
    logic [31:0] wbs_data_o;
    logic        wbs_we_i = 1'b0;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_ack_o;
    logic [7:0]  axis_tdata_o;
    logic        axis_tvalid_o;
    logic        axis_tready_i = 1'b0;
    logic        axis_tlast_o;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic       got_last_q[$];

    ptp_frame_gen dut (
        .clk(clk), .rst_n(rst_n),
        .wbs_addr_i(wbs_addr_i), .wbs_data_i(wbs_data_i), .wbs_data_o(wbs_data_o),
        .wbs_we_i(wbs_we_i), .wbs_stb_i(wbs_stb_i), .wbs_ack_o(wbs_ack_o),
        .axis_tdata_o(axis_tdata_o), .axis_tvalid_o(axis_tvalid_o),
        .axis_tready_i(axis_tready_i), .axis_tlast_o(axis_tlast_o)
    );

    always #5 clk = ~clk;

    // Reference frame built straight from the byte layout
    task automatic build_exp(input logic [3:0] mt, input logic [11:0] pn, input logic [15:0] seq,
                             input logic [31:0] corr, input int n, input logic [15:0] fill);
        logic [15:0] len;
        len = 16'(34 + n);
        exp_q.delete();
        for (int i = 0; i < 34 + n; i++) begin
            logic [7:0] b;
            b = 8'h00;
            if (i >= 34) b = ((i - 34) % 2 == 0) ? fill[15:8] : fill[7:0];
            else case (i)
                0: b = {4'h0, mt};
                1: b = 8'h02;
                2: b = len[15:8];
                3: b = len[7:0];
                12: b = corr[31:24];
                13: b = corr[23:16];
                14: b = corr[15:8];
                15: b = corr[7:0];
                28: b = {4'h0, pn[11:8]};
                29: b = pn[7:0];
                30: b = seq[15:8];
                31: b = seq[7:0];
                33: b = 8'h7F;
                default: b = 8'h00;
            endcase
            exp_q.push_back(b);
        end
    endtask

    // One Wishbone access; returns ack in the response cycle and in the one after
    task automatic wb_cycle(input logic [31:0] a, input logic we, input logic [31:0] d,
                            output logic ack1, output logic ack2, output logic [31:0] rd);
        @(posedge clk); #1;
        wbs_addr_i = a; wbs_we_i = we; wbs_data_i = d; wbs_stb_i = 1'b1;
        @(posedge clk); #1;
        ack1 = wbs_ack_o; rd = wbs_data_o;
        wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        @(posedge clk); #1;
        ack2 = wbs_ack_o;
    endtask

    // Sink: drive tready on the falling edge and record handshaken bytes
    task automatic collect(input bit rnd, input int max_cyc);
        int cyc;
        logic       pstall;
        logic [7:0] pdata;
        logic       plast;
        got_q.delete(); got_last_q.delete();
        cyc = 0; pstall = 1'b0; pdata = '0; plast = 1'b0;
        forever begin
            @(negedge clk);
            axis_tready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pstall) begin
                tests++;
                if (axis_tvalid_o !== 1'b1 || axis_tdata_o !== pdata || axis_tlast_o !== plast) begin
                    fails++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             axis_tvalid_o, axis_tdata_o, axis_tlast_o, pdata, plast);
                end
            end
            pstall = axis_tvalid_o & ~axis_tready_i;
            pdata = axis_tdata_o; plast = axis_tlast_o;
            if (axis_tvalid_o && axis_tready_i) begin
                got_q.push_back(axis_tdata_o);
                got_last_q.push_back(axis_tlast_o);
                if (axis_tlast_o) break;
            end
            cyc++;
            if (cyc > max_cyc) begin
                tests++; fails++;
                $display("FAIL collect_timeout: got %0d bytes want tlast within %0d cycles", got_q.size(), max_cyc);
                break;
            end
        end
        @(negedge clk);
        axis_tready_i = 1'b0;
        tests++;
        if (axis_tvalid_o !== 1'b0) begin
            fails++;
            $display("FAIL tvalid_after_last: got %b want 0", axis_tvalid_o);
        end
    endtask

    task automatic test_reset();
        logic a1, a2; logic [31:0] rd;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({wbs_ack_o, axis_tvalid_o, axis_tlast_o} !== 3'b000 || axis_tdata_o !== 8'h00 || wbs_data_o !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs: got ack=%b v=%b l=%b d=%h do=%h want all 0",
                     wbs_ack_o, axis_tvalid_o, axis_tlast_o, axis_tdata_o, wbs_data_o);
        end
        rst_n = 1'b1;
        wb_cycle(A_CTRL, 1'b0, 32'h0, a1, a2, rd);
        tests++;
        if (a1 !== 1'b1 || rd !== 32'h0) begin
            fails++;
            $display("FAIL reset_ctrl_read: got ack=%b data=%h want ack=1 data=0", a1, rd);
        end
    endtask

    task automatic test_regs();
        logic a1, a2; logic [31:0] rd;
        logic [31:0] addrs[4];
        logic [31:0] vals[4];
        addrs = '{A_HDR, A_CORR, A_BLEN, A_FILL};
        vals  = '{32'h1123_5555, 32'h0, 32'h16, 32'hAAAA};
        for (int i = 0; i < 4; i++) begin
            wb_cycle(addrs[i], 1'b1, vals[i], a1, a2, rd);
            tests++;
            if (a1 !== 1'b1 || a2 !== 1'b0) begin
                fails++;
                $display("FAIL wr_ack_%0d: got %b%b want 10", i, a1, a2);
            end
        end
        for (int i = 0; i < 4; i++) begin
            wb_cycle(addrs[i], 1'b0, 32'h0, a1, a2, rd);
            tests++;
            if (a1 !== 1'b1 || a2 !== 1'b0 || rd !== vals[i]) begin
                fails++;
                $display("FAIL readback_%0d: got ack=%b%b data=%h want ack=10 data=%h", i, a1, a2, rd, vals[i]);
            end
        end
        // Miss: acked, write ignored, read returns 0
        wb_cycle(32'h0400_0104, 1'b1, 32'hDEAD_BEEF, a1, a2, rd);
        tests++;
        if (a1 !== 1'b1) begin
            fails++;
            $display("FAIL miss_wr_ack: got %b want 1", a1);
        end
        wb_cycle(32'h0400_0104, 1'b0, 32'h0, a1, a2, rd);
        tests++;
        if (a1 !== 1'b1 || rd !== 32'h0) begin
            fails++;
            $display("FAIL miss_rd: got ack=%b data=%h want ack=1 data=0", a1, rd);
        end
        wb_cycle(A_HDR, 1'b0, 32'h0, a1, a2, rd);
        tests++;
        if (rd !== 32'h1123_5555) begin
            fails++;
            $display("FAIL miss_no_effect: got %h want 11235555", rd);
        end
    endtask

    task automatic test_stall_then_stream();
        logic a1, a2; logic [31:0] rd;
        int bad;
        axis_tready_i = 1'b0;
        wb_cycle(A_CTRL, 1'b1, 32'h1, a1, a2, rd);
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (axis_tvalid_o !== 1'b1 || axis_tdata_o !== 8'h01) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL stall_first_byte: got v=%b d=%h want v=1 d=01", axis_tvalid_o, axis_tdata_o);
        end
        wb_cycle(A_CTRL, 1'b0, 32'h0, a1, a2, rd);
        tests++;
        if (rd !== 32'h2) begin
            fails++;
            $display("FAIL ctrl_busy: got %h want 00000002", rd);
        end
        build_exp(4'h1, 12'h123, 16'h5555, 32'h0, 22, 16'hAAAA);
        collect(1'b0, 200);
        tests++;
        if (got_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL stream_len: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == exp_q.size() - 1)) begin
                fails++;
                $display("FAIL stream_byte_%0d: got %h last=%b want %h last=%b",
                         i, got_q[i], got_last_q[i], exp_q[i], i == exp_q.size() - 1);
            end
        end
    endtask

    task automatic test_random_tready();
        logic a1, a2; logic [31:0] rd;
        logic b1, b2; logic [31:0] rd2;
        int extra;
        // New header and fill to show the snapshot is taken; writes during the frame must not leak in
        wb_cycle(A_HDR, 1'b1, 32'hB0A5_1234, a1, a2, rd);
        wb_cycle(A_CORR, 1'b1, 32'h0102_0304, a1, a2, rd);
        wb_cycle(A_BLEN, 1'b1, 32'h5, a1, a2, rd);
        wb_cycle(A_FILL, 1'b1, 32'h3C5A, a1, a2, rd);
        build_exp(4'hB, 12'h0A5, 16'h1234, 32'h0102_0304, 5, 16'h3C5A);
        wb_cycle(A_CTRL, 1'b1, 32'h1, a1, a2, rd);
        fork
            collect(1'b1, 400);
            begin
                repeat (4) @(posedge clk);
                wb_cycle(A_CTRL, 1'b1, 32'h1, b1, b2, rd2);
                wb_cycle(A_FILL, 1'b1, 32'hFFFF, b1, b2, rd2);
            end
        join
        tests++;
        if (got_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL rnd_len: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == exp_q.size() - 1)) begin
                fails++;
                $display("FAIL rnd_byte_%0d: got %h last=%b want %h last=%b",
                         i, got_q[i], got_last_q[i], exp_q[i], i == exp_q.size() - 1);
            end
        end
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (axis_tvalid_o !== 1'b0) extra++;
        end
        tests++;
        if (extra != 0) begin
            fails++;
            $display("FAIL no_second_frame: got %0d valid cycles want 0", extra);
        end
    endtask

    task automatic test_zero_len();
        logic a1, a2; logic [31:0] rd;
        wb_cycle(A_HDR, 1'b1, 32'h1123_5555, a1, a2, rd);
        wb_cycle(A_BLEN, 1'b1, 32'h0, a1, a2, rd);
        build_exp(4'h1, 12'h123, 16'h5555, 32'h0102_0304, 0, 16'hFFFF);
        wb_cycle(A_CTRL, 1'b1, 32'h1, a1, a2, rd);
        collect(1'b0, 100);
        tests++;
        if (got_q.size() != 34) begin
            fails++;
            $display("FAIL zero_len_count: got %0d want 34", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == 33)) begin
                fails++;
                $display("FAIL zero_byte_%0d: got %h last=%b want %h last=%b",
                         i, got_q[i], got_last_q[i], exp_q[i], i == 33);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic a1, a2; logic [31:0] rd;
        axis_tready_i = 1'b0;
        wb_cycle(A_CTRL, 1'b1, 32'h1, a1, a2, rd);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (axis_tvalid_o !== 1'b0 || axis_tlast_o !== 1'b0 || axis_tdata_o !== 8'h00) begin
            fails++;
            $display("FAIL reset_abort: got v=%b l=%b d=%h want 0 0 00", axis_tvalid_o, axis_tlast_o, axis_tdata_o);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wb_cycle(A_HDR, 1'b0, 32'h0, a1, a2, rd);
        tests++;
        if (rd !== 32'h0) begin
            fails++;
            $display("FAIL reset_clears_hdr: got %h want 0", rd);
        end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_stall_then_stream();
        test_random_tready();
        test_zero_len();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
